store_size_unit: RTL and testbench

Store-size unit for the multicycle CPU datapath: the write-side counterpart of the load-size path. It turns a byte, halfword or word store into a memory transaction. Sub-word stores use a read-modify-write sequence that merges the low bits of the source register into the addressed lane of the existing memory word. The control unit starts it with a one-cycle pulse and waits for `done` (or `storeExc`) before advancing.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/ss_merge.sv | 40 ++++
 rtl/store_size_unit.sv | 129 ++++++++++++
 tb/tb_store_size_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared encodings for the store-size datapath (store selects,
//               FSM states, lane widths).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [1:0] SS_BYTE = 2'b00;
    localparam logic [1:0] SS_HALF = 2'b01;
    localparam logic [1:0] SS_WORD = 2'b10;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_EXC   = 3'd4
    } ss_state_t;

endpackage
`default_nettype wire

// File: rtl/ss_merge.sv
`default_nettype none
// ============================================================================
// Module      : ss_merge
// Description : Combinational lane merge: replaces the selected byte/halfword
//               lane of oldWord with the low bits of data (little-endian).
// Revision    : 1.0 - initial release
// ============================================================================
module ss_merge
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0] oldWord,
    input  logic [WORD_W-1:0] data,
    input  logic [1:0]        sel,
    input  logic [1:0]        offset,
    output logic [WORD_W-1:0] merged
);

    always_comb begin
        merged = oldWord;
        case (sel)
            SS_BYTE: begin
                case (offset)
                    2'd0:    merged[7:0]   = data[BYTE_W-1:0];
                    2'd1:    merged[15:8]  = data[BYTE_W-1:0];
                    2'd2:    merged[23:16] = data[BYTE_W-1:0];
                    default: merged[31:24] = data[BYTE_W-1:0];
                endcase
            end
            SS_HALF: begin
                // offset[0] is guaranteed zero by the alignment check upstream
                if (offset[1]) merged[31:16] = data[HALF_W-1:0];
                else           merged[15:0]  = data[HALF_W-1:0];
            end
            SS_WORD: merged = data;
            default: merged = oldWord;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_size_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_size_unit
// Description : Byte/halfword/word store sequencer; sub-word stores use a
//               read-modify-write through ss_merge.
// Revision    : 1.0 - initial release
// ============================================================================
module store_size_unit
    import cpu_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  storeSel,
    input  logic [31:0] addr,
    input  logic [31:0] rtData,
    input  logic [31:0] memRData,
    output logic [31:0] memAddr,
    output logic        memWr,
    output logic [31:0] memWData,
    output logic        busy,
    output logic        done,
    output logic        storeExc
);

    localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

    ss_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_sel;
    logic [1:0]         r_offset;
    logic [31:0]        r_data;
    logic [31:0]        r_memAddr;
    logic [31:0]        r_memWData;
    logic               r_memWr;
    logic               r_busy;
    logic               r_done;
    logic               r_storeExc;

    logic               w_misaligned;
    logic [31:0]        w_merged;

    assign w_misaligned = (storeSel == 2'b11)
                       || (storeSel == SS_HALF && addr[0])
                       || (storeSel == SS_WORD && addr[1:0] != 2'b00);

    ss_merge u_merge (
        .oldWord (memRData),
        .data    (r_data),
        .sel     (r_sel),
        .offset  (r_offset),
        .merged  (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sel      <= SS_BYTE;
            r_offset   <= 2'b00;
            r_data     <= '0;
            r_memAddr  <= '0;
            r_memWData <= '0;
            r_memWr    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_storeExc <= 1'b0;
        end else begin
            r_memWr    <= 1'b0;
            r_done     <= 1'b0;
            r_storeExc <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sel     <= storeSel;
                        r_offset  <= addr[1:0];
                        r_data    <= rtData;
                        r_memAddr <= {addr[31:2], 2'b00};
                        r_busy    <= 1'b1;
                        if (w_misaligned) begin
                            r_state    <= ST_EXC;
                            r_storeExc <= 1'b1;
                        end else if (storeSel == SS_WORD) begin
                            r_state    <= ST_WRITE;
                            r_memWr    <= 1'b1;
                            r_memWData <= rtData;
                        end else begin
                            r_state <= ST_READ;
                            r_cnt   <= CNT_W'(READ_LATENCY);
                        end
                    end
                end
                ST_READ: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_memWData <= w_merged;
                        r_memWr    <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= ST_WRITE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE, ST_EXC: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign memAddr  = r_memAddr;
    assign memWr    = r_memWr;
    assign memWData = r_memWData;
    assign busy     = r_busy;
    assign done     = r_done;
    assign storeExc = r_storeExc;

endmodule
`default_nettype wire

// File: tb/tb_store_size_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_size_unit
// Description : Directed self-checking bench; one instance with read latency 1
//               and one with read latency 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_size_unit;

    logic        clk;
    logic        reset;
    logic        start1;
    logic        start3;
    logic [1:0]  storeSel;
    logic [31:0] addr;
    logic [31:0] rtData;
    logic [31:0] memRData;

    logic [31:0] memAddr1, memWData1, memAddr3, memWData3;
    logic        memWr1, busy1, done1, exc1;
    logic        memWr3, busy3, done3, exc3;

    int n_checks = 0;
    int n_pass   = 0;

    store_size_unit #(.READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .storeSel(storeSel),
        .addr(addr), .rtData(rtData), .memRData(memRData),
        .memAddr(memAddr1), .memWr(memWr1), .memWData(memWData1),
        .busy(busy1), .done(done1), .storeExc(exc1)
    );

    store_size_unit #(.READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .storeSel(storeSel),
        .addr(addr), .rtData(rtData), .memRData(memRData),
        .memAddr(memAddr3), .memWr(memWr3), .memWData(memWData3),
        .busy(busy3), .done(done3), .storeExc(exc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Pulse start for one sampling edge; returns at the middle of cycle 1.
    task automatic issue(input bit use3, input logic [1:0] sel, input logic [31:0] a,
                         input logic [31:0] d);
        @(negedge clk);
        storeSel = sel; addr = a; rtData = d;
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0;
    endtask

    task automatic check_exc(input string tag, input logic [1:0] sel, input logic [31:0] a);
        issue(1'b0, sel, a, 32'hFFFF_FFFF);
        check({tag, "_exc_c1"},  {31'd0, exc1},   32'd1);
        check({tag, "_wr_c1"},   {31'd0, memWr1}, 32'd0);
        check({tag, "_done_c1"}, {31'd0, done1},  32'd0);
        @(negedge clk);
        check({tag, "_c2"}, {28'd0, exc1, memWr1, done1, busy1}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
        storeSel = 2'b00; addr = '0; rtData = '0; memRData = '0;
        @(negedge clk); @(negedge clk);
        check("rst_addr",  memAddr1, 32'h0);
        check("rst_wdata", memWData1, 32'h0);
        check("rst_ctrl",  {28'd0, memWr1, busy1, done1, exc1}, 32'h0);
        reset = 1'b0;

        // Word store
        issue(1'b0, 2'b10, 32'h100, 32'hDEAD_BEEF);
        check("word_wr_c1",    {31'd0, memWr1}, 32'd1);
        check("word_addr_c1",  memAddr1, 32'h100);
        check("word_wdata_c1", memWData1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("word_done_c2",  {30'd0, done1, memWr1}, 32'b10);
        @(negedge clk);
        check("word_idle_c3",  {30'd0, busy1, done1}, 32'b00);

        // Byte store, latency 1
        memRData = 32'h1122_3344;
        issue(1'b0, 2'b00, 32'h203, 32'h0000_00AB);
        check("byte_read_c1", {30'd0, busy1, memWr1}, 32'b10);
        @(negedge clk);
        check("byte_wr_c2",    {31'd0, memWr1}, 32'd1);
        check("byte_addr_c2",  memAddr1, 32'h200);
        check("byte_wdata_c2", memWData1, 32'hAB22_3344);
        @(negedge clk);
        check("byte_done_c3",  {30'd0, done1, memWr1}, 32'b10);
        @(negedge clk);

        // Halfword at lower lane, latency 1
        memRData = 32'hFFFF_FFFF;
        issue(1'b0, 2'b01, 32'h08, 32'h1234_CAFE);
        @(negedge clk);
        check("halflo_wdata", memWData1, 32'hFFFF_CAFE);
        @(negedge clk); @(negedge clk);

        // Halfword at upper lane (addr[1]=1), latency 3
        issue(1'b1, 2'b01, 32'h0A, 32'h1234_CAFE);
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("half3_nowr_c%0d", c), {31'd0, memWr3}, 32'd0);
            @(negedge clk);
        end
        check("half3_wr_c4",    {31'd0, memWr3}, 32'd1);
        check("half3_addr_c4",  memAddr3, 32'h08);
        check("half3_wdata_c4", memWData3, 32'hCAFE_FFFF);
        @(negedge clk);
        check("half3_done_c5",  {31'd0, done3}, 32'd1);
        @(negedge clk);

        // Exceptions
        check_exc("half_mis", 2'b01, 32'h101);
        check_exc("word_mis", 2'b10, 32'h102);
        check_exc("sel_rsv",  2'b11, 32'h100);

        // Start during READ is ignored
        memRData = 32'h1122_3344;
        issue(1'b1, 2'b00, 32'h201, 32'h0000_0055);
        start3 = 1'b1; storeSel = 2'b10; addr = 32'h300; rtData = 32'hFFFF_FFFF;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk); @(negedge clk);
        check("busy_wr_c4",    {31'd0, memWr3}, 32'd1);
        check("busy_addr_c4",  memAddr3, 32'h200);
        check("busy_wdata_c4", memWData3, 32'h1122_5544);
        @(negedge clk);
        check("busy_done_c5",  {31'd0, done3}, 32'd1);
        @(negedge clk);
        check("busy_idle_c6",  {30'd0, busy3, memWr3}, 32'd0);

        // Reset in cycle 1 of a byte store
        issue(1'b0, 2'b00, 32'h203, 32'h0000_00AB);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstrd_addr",  memAddr1, 32'h0);
        check("rstrd_wdata", memWData1, 32'h0);
        check("rstrd_ctrl",  {28'd0, memWr1, busy1, done1, exc1}, 32'h0);
        @(negedge clk);
        check("rstrd_nowr",  {31'd0, memWr1}, 32'd0);

        // Reset during WRITE: done suppressed, idle next cycle
        issue(1'b0, 2'b10, 32'h40, 32'h0BAD_F00D);
        check("rstwr_wr_c1", {31'd0, memWr1}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstwr_c2", {29'd0, memWr1, busy1, done1}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
